// File: rtl/hazard_controller_if.sv
// Pipeline hazard control bundle between the datapath and the hazard controller.
// Latency: none (plain wires); the controller's outputs respond in the same cycle.
// Backpressure: expressed by pc_en/ifid_en going low; there is no valid/ready pair here.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  // ID / EX observations from the datapath
  logic [4:0]       Registro1;
  logic [4:0]       Registro2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       Rd_execute;
  logic             ex_memread;
  logic             ex_muldiv;
  logic             branch_taken;
  logic             md_done;
  logic             halt_req;

  // Controls back to the datapath
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_bubble;
  logic             md_start;
  logic             md_error;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Datapath side: reports pipeline status, obeys the controls
  modport master (
    output Registro1, Registro2, id_uses_rs1, id_uses_rs2, Rd_execute,
           ex_memread, ex_muldiv, branch_taken, md_done, halt_req,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_bubble,
           md_start, md_error, halted, stall_count, flush_count
  );

  // Controller side
  modport slave (
    input  Registro1, Registro2, id_uses_rs1, id_uses_rs2, Rd_execute,
           ex_memread, ex_muldiv, branch_taken, md_done, halt_req,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_bubble,
           md_start, md_error, halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Central 5-stage pipeline sequencer: load-use bubble, branch flush, MUL/DIV freeze, halt.
// Latency: control outputs are combinational from state and inputs (act in the same cycle).
// Backpressure: stalls the front end by dropping pc_en/ifid_en; MUL/DIV wait bounded by MD_TIMEOUT.
module hazard_controller #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  // Last wait-counter value before giving up on the MUL/DIV unit
  localparam logic [7:0]       WAIT_LAST = 8'(MD_TIMEOUT - 1);
  localparam logic [7:0]       WAIT_ONE  = 8'd1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             md_error_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic load_use;
  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_bubble;
  logic md_start;
  logic flush_evt;

  // A load in EX whose destination is a live source of the ID instruction
  // cannot be covered by forwarding; x0 never creates a dependency.
  assign load_use = bus.ex_memread && (bus.Rd_execute != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.Registro1 == bus.Rd_execute)) ||
                     (bus.id_uses_rs2 && (bus.Registro2 == bus.Rd_execute)));

  // Decode pipeline controls from the current state and this cycle's hazards;
  // during reset the pipeline is left free-running with no flushes.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    md_start     = 1'b0;
    flush_evt    = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (bus.branch_taken) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; fetch redirects.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else if (bus.ex_muldiv) begin
            md_start     = 1'b1;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_bubble = 1'b1;
          end else if (bus.halt_req || load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          // The md_done cycle lets the held MUL/DIV result advance into MEM.
          if (!bus.md_done) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_bubble = 1'b1;
          end
        end
        HALT: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state, MUL/DIV wait timer, sticky timeout flag and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      md_error_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      if (!pc_en && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (flush_evt && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + CNT_ONE;
      end
      case (state)
        RUN: begin
          if (!bus.branch_taken) begin
            if (bus.ex_muldiv) begin
              state    <= MD_WAIT;
              wait_cnt <= '0;
            end else if (bus.halt_req) begin
              state <= HALT;
            end
          end
        end
        MD_WAIT: begin
          // halt_req is not looked at here: it is serviced once back in RUN.
          if (bus.md_done) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            md_error_q <= 1'b1;
            state      <= RUN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        HALT: begin
          if (!bus.halt_req) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.md_start     = md_start;
  assign bus.md_error     = md_error_q;
  assign bus.halted       = (state == HALT);
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus a randomized run against a reference model.
// Latency: controls are sampled at the falling edge, counters after the rising edge.
// Backpressure: stalls are observed through pc_en/ifid_en and the stall counter.
module tb_hazard_controller;
  localparam int CNT_W      = 4;
  localparam int MD_TIMEOUT = 8;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_controller_if #(.CNT_W(CNT_W)) bus ();

  hazard_controller #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: mode flags, cycles spent waiting, sticky error, counters
  bit         m_md, m_halt, m_err;
  int         m_wait, m_stall, m_flush;
  logic [6:0] e_out;  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_bubble, md_start, halted}

  function automatic logic [6:0] outv();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
            bus.exmem_bubble, bus.md_start, bus.halted};
  endfunction

  function automatic void model_reset();
    m_md = 0; m_halt = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endfunction

  // Expected controls: a hazard exists when the loaded register is a nonzero register actually read in ID
  function automatic void model_outputs();
    bit hz;
    hz = bus.ex_memread && (bus.Rd_execute != 0) &&
         ((bus.id_uses_rs1 && bus.Registro1 == bus.Rd_execute) ||
          (bus.id_uses_rs2 && bus.Registro2 == bus.Rd_execute));
    if (m_md)                   e_out = bus.md_done ? 7'b1100000 : 7'b0000100;
    else if (m_halt)            e_out = 7'b0001001;
    else if (bus.branch_taken)  e_out = 7'b1111000;
    else if (bus.ex_muldiv)     e_out = 7'b0000110;
    else if (bus.halt_req || hz) e_out = 7'b0001000;
    else                        e_out = 7'b1100000;
  endfunction

  // Advance the model by one clock using the inputs held this cycle
  function automatic void model_advance();
    if (!e_out[6] && m_stall < CMAX) m_stall++;
    if (m_md) begin
      m_wait++;
      if (bus.md_done) m_md = 0;
      else if (m_wait >= MD_TIMEOUT) begin m_err = 1; m_md = 0; end
    end else if (m_halt) begin
      if (!bus.halt_req) m_halt = 0;
    end else if (bus.branch_taken) begin
      if (m_flush < CMAX) m_flush++;
    end else if (bus.ex_muldiv) begin
      m_md = 1; m_wait = 0;
    end else if (bus.halt_req) begin
      m_halt = 1;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Registro1 = '0; bus.Registro2 = '0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.Rd_execute = '0; bus.ex_memread = 0; bus.ex_muldiv = 0; bus.branch_taken = 0;
    bus.md_done = 0; bus.halt_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.ex_memread = 1; bus.Rd_execute = 5; bus.Registro1 = 5; bus.id_uses_rs1 = 1;
    bus.ex_muldiv = 1; bus.halt_req = 1; bus.branch_taken = 1; bus.md_done = 1;
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL reset_outputs got %b exp 1100000", outv()); end
    cyc(); cyc();
    #4;
    checks++; if (bus.md_error !== 1'b0) begin errors++; $display("FAIL reset_md_error got %b exp 0", bus.md_error); end
    checks++; if (bus.stall_count !== 0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.stall_count); end
    checks++; if (bus.flush_count !== 0) begin errors++; $display("FAIL reset_flush got %0d exp 0", bus.flush_count); end
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL reset_outputs2 got %b exp 1100000", outv()); end
    clear_inputs();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_memread = 1; bus.Rd_execute = 5; bus.Registro1 = 5; bus.id_uses_rs1 = 1;
    bus.Registro2 = 7; bus.id_uses_rs2 = 1;
    #4;
    checks++; if (outv() !== 7'b0001000) begin errors++; $display("FAIL lu_stall got %b exp 0001000", outv()); end
    cyc();
    bus.ex_memread = 0; bus.Rd_execute = 0;
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL lu_release got %b exp 1100000", outv()); end
    checks++; if (bus.stall_count !== 1) begin errors++; $display("FAIL lu_stall_count got %0d exp 1", bus.stall_count); end
    // rs2-side dependency
    cyc();
    bus.ex_memread = 1; bus.Rd_execute = 9; bus.Registro1 = 3; bus.Registro2 = 9;
    bus.id_uses_rs1 = 1; bus.id_uses_rs2 = 1;
    #4;
    checks++; if (outv() !== 7'b0001000) begin errors++; $display("FAIL lu_rs2 got %b exp 0001000", outv()); end
    cyc();
    clear_inputs();
    #4;
    checks++; if (bus.stall_count !== 2) begin errors++; $display("FAIL lu_rs2_count got %0d exp 2", bus.stall_count); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    bus.ex_memread = 1; bus.Rd_execute = 0; bus.Registro1 = 0; bus.id_uses_rs1 = 1;
    #4;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL nohz_x0 pc_en got %b exp 1", bus.pc_en); end
    cyc();
    bus.Rd_execute = 5; bus.Registro1 = 3; bus.Registro2 = 5; bus.id_uses_rs2 = 0;
    #4;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL nohz_rs2_unused pc_en got %b exp 1", bus.pc_en); end
    cyc();
    bus.ex_memread = 0; bus.Registro1 = 5;
    #4;
    checks++; if (bus.pc_en !== 1'b1) begin errors++; $display("FAIL nohz_not_load pc_en got %b exp 1", bus.pc_en); end
    cyc();
    clear_inputs();
    bus.md_done = 1;
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL stray_md_done got %b exp 1100000", outv()); end
    cyc();
    clear_inputs();
    #4;
    checks++; if (bus.stall_count !== 0) begin errors++; $display("FAIL nohz_count got %0d exp 0", bus.stall_count); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    bus.ex_memread = 1; bus.Rd_execute = 5; bus.Registro1 = 5; bus.id_uses_rs1 = 1;
    bus.branch_taken = 1; bus.ex_muldiv = 1; bus.halt_req = 1;
    #4;
    checks++; if (outv() !== 7'b1111000) begin errors++; $display("FAIL br_prio got %b exp 1111000", outv()); end
    cyc();
    clear_inputs();
    #4;
    checks++; if (bus.flush_count !== 1) begin errors++; $display("FAIL br_flush_count got %0d exp 1", bus.flush_count); end
    checks++; if (bus.stall_count !== 0) begin errors++; $display("FAIL br_stall_count got %0d exp 0", bus.stall_count); end
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL br_after got %b exp 1100000", outv()); end
  endtask

  task automatic test_muldiv();
    int starts;
    do_reset();
    starts = 0;
    bus.ex_muldiv = 1;
    #4;
    checks++; if (outv() !== 7'b0000110) begin errors++; $display("FAIL md_start_cycle got %b exp 0000110", outv()); end
    cyc();
    bus.halt_req = 1;  // must be deferred until RUN
    for (int i = 0; i < 3; i++) begin
      #4;
      if (bus.md_start) starts++;
      checks++; if (outv() !== 7'b0000100) begin errors++; $display("FAIL md_wait%0d got %b exp 0000100", i, outv()); end
      cyc();
    end
    bus.md_done = 1;
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL md_done_cycle got %b exp 1100000", outv()); end
    checks++; if (starts !== 0) begin errors++; $display("FAIL md_restart got %0d exp 0", starts); end
    cyc();
    bus.md_done = 0; bus.ex_muldiv = 0;
    #4;
    checks++; if (bus.stall_count !== 4) begin errors++; $display("FAIL md_stall_count got %0d exp 4", bus.stall_count); end
    checks++; if (outv() !== 7'b0001000) begin errors++; $display("FAIL md_deferred_halt got %b exp 0001000", outv()); end
    cyc();
    bus.halt_req = 0;
    #4;
    checks++; if (outv() !== 7'b0001001) begin errors++; $display("FAIL md_halt_state got %b exp 0001001", outv()); end
    cyc();
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL md_back_run got %b exp 1100000", outv()); end
    checks++; if (bus.md_error !== 1'b0) begin errors++; $display("FAIL md_no_error got %b exp 0", bus.md_error); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.ex_muldiv = 1;
    cyc();
    bus.ex_muldiv = 0;
    for (int i = 0; i < MD_TIMEOUT; i++) begin
      #4;
      checks++; if ({bus.pc_en, bus.exmem_bubble, bus.md_error} !== 3'b010) begin
        errors++; $display("FAIL to_wait%0d pc_en/bubble/err got %b exp 010", i, {bus.pc_en, bus.exmem_bubble, bus.md_error});
      end
      cyc();
    end
    #4;
    checks++; if (bus.md_error !== 1'b1) begin errors++; $display("FAIL to_error got %b exp 1", bus.md_error); end
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL to_run got %b exp 1100000", outv()); end
    checks++; if (bus.stall_count !== 1 + MD_TIMEOUT) begin errors++; $display("FAIL to_stall_count got %0d exp %0d", bus.stall_count, 1 + MD_TIMEOUT); end
    repeat (20) cyc();
    #4;
    checks++; if (bus.md_error !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", bus.md_error); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.md_error !== 1'b0) begin errors++; $display("FAIL to_reset_clear got %b exp 0", bus.md_error); end
    cyc();
    rst_n = 1'b1;
    // Reset in the middle of a wait aborts it with no new start pulse
    bus.ex_muldiv = 1;
    cyc();
    bus.ex_muldiv = 0;
    cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL to_abort_in_reset got %b exp 1100000", outv()); end
    cyc();
    rst_n = 1'b1;
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL to_abort_after got %b exp 1100000", outv()); end
    checks++; if (bus.stall_count !== 0) begin errors++; $display("FAIL to_abort_count got %0d exp 0", bus.stall_count); end
  endtask

  task automatic test_halt_saturation();
    int n_halted, n_stall;
    do_reset();
    n_halted = 0; n_stall = 0;
    for (int k = 0; k < 6; k++) begin
      bus.halt_req = (k < 3);
      #4;
      if (bus.halted) n_halted++;
      if (!bus.pc_en) n_stall++;
      cyc();
    end
    checks++; if (n_halted !== 3) begin errors++; $display("FAIL halt_cycles got %0d exp 3", n_halted); end
    checks++; if (n_stall !== 4) begin errors++; $display("FAIL halt_stall_cycles got %0d exp 4", n_stall); end
    #4;
    checks++; if (outv() !== 7'b1100000) begin errors++; $display("FAIL halt_release got %b exp 1100000", outv()); end
    bus.halt_req = 1;
    repeat (20) cyc();
    #4;
    checks++; if (bus.stall_count !== CMAX) begin errors++; $display("FAIL stall_saturate got %0d exp %0d", bus.stall_count, CMAX); end
    bus.halt_req = 0;
    cyc(); cyc();
    bus.branch_taken = 1;
    repeat (20) cyc();
    bus.branch_taken = 0;
    #4;
    checks++; if (bus.flush_count !== CMAX) begin errors++; $display("FAIL flush_saturate got %0d exp %0d", bus.flush_count, CMAX); end
    checks++; if (bus.stall_count !== CMAX) begin errors++; $display("FAIL stall_hold got %0d exp %0d", bus.stall_count, CMAX); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      bus.Registro1    = 5'($urandom_range(0, 3));
      bus.Registro2    = 5'($urandom_range(0, 3));
      bus.Rd_execute   = 5'($urandom_range(0, 3));
      bus.id_uses_rs1  = 1'($urandom_range(0, 1));
      bus.id_uses_rs2  = 1'($urandom_range(0, 1));
      bus.ex_memread   = 1'($urandom_range(0, 1));
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.ex_muldiv    = ($urandom_range(0, 7) == 0);
      bus.md_done      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.halt_req = ~bus.halt_req;
      #4;
      model_outputs();
      checks++; if (outv() !== e_out) begin errors++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", c, outv(), e_out); end
      checks++; if ({bus.md_error, bus.stall_count, bus.flush_count} !== {m_err, CNT_W'(m_stall), CNT_W'(m_flush)}) begin
        errors++; $display("FAIL rnd_state cyc %0d err/stall/flush got %b/%0d/%0d exp %b/%0d/%0d",
                            c, bus.md_error, bus.stall_count, bus.flush_count, m_err, m_stall, m_flush);
      end
      model_advance();
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_priority();
    test_muldiv();
    test_timeout();
    test_halt_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
